// File: rtl/alu_sign_extend_pkg.sv
// Shared definitions for the rv32i execute-stage slice: data width,
// ALU operation codes and immediate format codes.
package alu_sign_extend_pkg;

    localparam int unsigned INSTR_WIDTH = 32;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLL  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_SLT  = 4'b1000,
        ALU_SLTU = 4'b1001,
        ALU_NOP  = 4'b1111
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_U = 3'b011,
        IMM_J = 3'b100
    } imm_fmt_e;

endpackage

// File: rtl/alu_sign_extend_sign_extend.sv
// Combinational immediate decoder. src carries instruction bits [31:7],
// so src[24] is the instruction sign bit. Unused formats yield zero.
module sign_extend
    import alu_sign_extend_pkg::*;
(
    input  logic [24:0]            src,
    input  logic [2:0]             imm_src,
    output logic [INSTR_WIDTH-1:0] imm_signed
);

    // Reassemble the immediate for the selected format and sign-extend it.
    always_comb begin
        imm_signed = '0;
        case (imm_src)
            IMM_I: imm_signed = {{20{src[24]}}, src[24:13]};
            IMM_S: imm_signed = {{20{src[24]}}, src[24:18], src[4:0]};
            IMM_B: imm_signed = {{19{src[24]}}, src[24], src[0], src[23:18], src[4:1], 1'b0};
            IMM_U: imm_signed = {src[24:5], 12'b0};
            IMM_J: imm_signed = {{11{src[24]}}, src[24], src[12:5], src[13], src[23:14], 1'b0};
            default: imm_signed = '0;
        endcase
    end

endmodule

// File: rtl/alu_sign_extend.sv
// Execute-stage slice: immediate decode, operand B select, ALU and the
// registered result/zero pair. Defining RV32I_ALU_SHIFT_CMP_EN enables
// SLL/SRL/SRA/SLT/SLTU; otherwise those codes produce zero like NOP.
module alu_sign_extend
    import alu_sign_extend_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [3:0]             alu_ctrl,
    input  logic                   alu_src,
    input  logic [INSTR_WIDTH-1:0] src1,
    input  logic [INSTR_WIDTH-1:0] src2,
    input  logic [24:0]            src,
    input  logic [2:0]             imm_src,
    output logic [INSTR_WIDTH-1:0] imm_signed,
    output logic [INSTR_WIDTH-1:0] results,
    output logic                   zero
);

    logic [INSTR_WIDTH-1:0] operand_b;
    logic [INSTR_WIDTH-1:0] next_result;

    sign_extend u_sign_extend (
        .src        (src),
        .imm_src    (imm_src),
        .imm_signed (imm_signed)
    );

    // Operand B comes from the decoded immediate or the register file.
    always_comb begin
        operand_b = alu_src ? imm_signed : src2;
    end

    // ALU operation; all arithmetic wraps modulo 2^32.
    always_comb begin
        next_result = '0;
        case (alu_ctrl)
            ALU_ADD:  next_result = src1 + operand_b;
            ALU_SUB:  next_result = src1 - operand_b;
            ALU_AND:  next_result = src1 & operand_b;
            ALU_OR:   next_result = src1 | operand_b;
            ALU_XOR:  next_result = src1 ^ operand_b;
`ifdef RV32I_ALU_SHIFT_CMP_EN
            ALU_SLL:  next_result = src1 << operand_b[4:0];
            ALU_SRL:  next_result = src1 >> operand_b[4:0];
            ALU_SRA:  next_result = $unsigned($signed(src1) >>> operand_b[4:0]);
            ALU_SLT:  next_result = ($signed(src1) < $signed(operand_b)) ? 32'd1 : '0;
            ALU_SLTU: next_result = (src1 < operand_b) ? 32'd1 : '0;
`endif
            default:  next_result = '0;
        endcase
    end

    // Register result and zero flag together; reset forces 0 / 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            results <= '0;
            zero    <= 1'b1;
        end else begin
            results <= next_result;
            zero    <= (next_result == '0);
        end
    end

endmodule

// File: tb/tb_alu_sign_extend.sv
// Self-checking bench for alu_sign_extend: directed cases followed by
// randomized operations compared against an ISA-level reference model.
module tb_alu_sign_extend;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  alu_ctrl;
    logic        alu_src;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [24:0] src;
    logic [2:0]  imm_src;
    logic [31:0] imm_signed;
    logic [31:0] results;
    logic        zero;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_imm;
    logic [31:0] exp_res;

    alu_sign_extend dut (
        .clk        (clk),
        .rst        (rst),
        .alu_ctrl   (alu_ctrl),
        .alu_src    (alu_src),
        .src1       (src1),
        .src2       (src2),
        .src        (src),
        .imm_src    (imm_src),
        .imm_signed (imm_signed),
        .results    (results),
        .zero       (zero)
    );

    always #5 clk = ~clk;

`ifdef RV32I_ALU_SHIFT_CMP_EN
    localparam bit SHIFT_CMP = 1'b1;
`else
    localparam bit SHIFT_CMP = 1'b0;
`endif

    // Interpret the low 'bits' bits of v as a two's-complement number.
    function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
        longint val;
        val = longint'(v) & ((64'd1 << bits) - 1);
        if (val >= (64'd1 << (bits - 1)))
            val = val - (64'd1 << bits);
        return 32'(val);
    endfunction

    // Immediate value as the ISA defines it, using full instruction bit numbers.
    function automatic logic [31:0] model_imm(input logic [24:0] s, input logic [2:0] fmt);
        logic [31:0] ins;
        logic [31:0] raw;
        ins = {s, 7'b0};
        case (fmt)
            3'd0: return sext(32'(ins[31:20]), 12);
            3'd1: return sext(32'({ins[31:25], ins[11:7]}), 12);
            3'd2: begin
                raw = 32'(ins[31]) * 4096 + 32'(ins[7]) * 2048 + 32'(ins[30:25]) * 32 + 32'(ins[11:8]) * 2;
                return sext(raw, 13);
            end
            3'd3: return 32'(ins[31:12]) * 4096;
            3'd4: begin
                raw = 32'(ins[31]) * 1048576 + 32'(ins[19:12]) * 4096 + 32'(ins[20]) * 2048 + 32'(ins[30:21]) * 2;
                return sext(raw, 21);
            end
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] model_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        longint sa;
        longint sb;
        sh = int'(b % 32);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            4'd0: return 32'(longint'(a) + longint'(b));
            4'd1: return 32'(longint'(a) - longint'(b));
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            default: ;
        endcase
        if (!SHIFT_CMP) return 32'h0;
        case (op)
            4'd5: return 32'(longint'(a) * (64'd1 << sh));
            4'd6: return 32'(longint'(a) / (64'd1 << sh));
            4'd7: begin
                // Floor division by 2^sh gives arithmetic shift semantics.
                if (sa >= 0) return 32'(sa / (64'd1 << sh));
                return 32'(-((-sa + (64'd1 << sh) - 1) / (64'd1 << sh)));
            end
            4'd8: return (sa < sb) ? 32'd1 : 32'd0;
            4'd9: return (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
            default: return 32'h0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    // Drive one operation, check the immediate, clock it, check the registered outputs.
    task automatic do_op(input logic r, input logic [3:0] op, input logic asrc,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [24:0] s, input logic [2:0] fmt);
        logic [31:0] bsel;
        rst = r; alu_ctrl = op; alu_src = asrc; src1 = a; src2 = b; src = s; imm_src = fmt;
        exp_imm = model_imm(s, fmt);
        bsel = asrc ? exp_imm : b;
        exp_res = r ? 32'h0 : model_alu(op, a, bsel);
        #1;
        check("imm_signed", imm_signed, exp_imm);
        @(posedge clk);
        #1;
        check("results", results, exp_res);
        check("zero", {31'b0, zero}, {31'b0, exp_res == 32'h0});
    endtask

    initial begin
        rst = 1'b1; alu_ctrl = 4'hF; alu_src = 1'b0; src1 = '0; src2 = '0; src = '0; imm_src = 3'b111;
        @(negedge clk);

        // Reset, with a live ADD underneath to confirm reset wins.
        do_op(1'b1, 4'hF, 1'b0, 32'h0, 32'h0, 25'h0, 3'b111);
        check("rst_results", results, 32'h0);
        check("rst_zero", {31'b0, zero}, 32'd1);
        check("rst_imm", imm_signed, 32'h0);
        do_op(1'b1, 4'h0, 1'b0, 32'h1234, 32'h1, 25'h0, 3'b111);
        check("rst_override", results, 32'h0);

        // I-type negative immediate.
        do_op(1'b0, 4'h0, 1'b1, 32'h2000, 32'h0, 25'h1F80000, 3'b000);
        check("i_imm", imm_signed, 32'hFFFFFFC0);
        check("i_add", results, 32'h1FC0);

        // S-type positive and negative.
        do_op(1'b0, 4'h0, 1'b1, 32'h3000, 32'h0, 25'h0070005, 3'b001);
        check("s_imm_pos", imm_signed, 32'h25);
        check("s_add_pos", results, 32'h3025);
        do_op(1'b0, 4'h0, 1'b1, 32'h4000, 32'h0, 25'h1700005, 3'b001);
        check("s_imm_neg", imm_signed, 32'hFFFFFB85);
        check("s_add_neg", results, 32'h3B85);

        // Register path.
        do_op(1'b0, 4'h0, 1'b0, 32'h5000, 32'h0FFF, 25'h1FFFFFF, 3'b000);
        check("reg_add", results, 32'h5FFF);
        check("reg_zero", {31'b0, zero}, 32'd0);

        // SUB to zero, then NOP.
        do_op(1'b0, 4'h1, 1'b0, 32'h1234, 32'h1234, 25'h0, 3'b000);
        check("sub_zero_res", results, 32'h0);
        check("sub_zero_flag", {31'b0, zero}, 32'd1);
        do_op(1'b0, 4'hF, 1'b0, 32'hDEADBEEF, 32'h12345678, 25'h1ABCDEF, 3'b011);
        check("nop", results, 32'h0);

        // Shifts and compares; zero when the feature is compiled out.
        do_op(1'b0, 4'h7, 1'b0, 32'h80000000, 32'd4, 25'h0, 3'b000);
        check("sra", results, SHIFT_CMP ? 32'hF8000000 : 32'h0);
        do_op(1'b0, 4'h8, 1'b0, 32'hFFFFFFFF, 32'd1, 25'h0, 3'b000);
        check("slt", results, SHIFT_CMP ? 32'd1 : 32'h0);
        do_op(1'b0, 4'h9, 1'b0, 32'hFFFFFFFF, 32'd1, 25'h0, 3'b000);
        check("sltu", results, 32'h0);

        // Hold: stable inputs keep the outputs.
        @(posedge clk);
        #1;
        check("hold", results, exp_res);

        // Randomized operations against the model.
        for (int i = 0; i < 400; i++) begin
            do_op(($urandom % 20) == 0, 4'($urandom), 1'($urandom),
                  ($urandom % 8 == 0) ? 32'h0 : $urandom,
                  ($urandom % 8 == 0) ? $urandom_range(0, 40) : $urandom,
                  25'($urandom), 3'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard timeout so the run can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_sign_extend.md
# alu_sign_extend

Execute-stage datapath slice of the rv32i single-core processor. It decodes the immediate field of the current instruction into a sign-extended 32-bit operand. It selects either that immediate or the second register operand as ALU operand B and performs the requested ALU operation. The result and zero flag are registered for the writeback/memory path and for branch decisions.

## Interface
- Parameters: none. Data width is fixed at `INSTR_WIDTH` = 32 from the shared package.
- One clock; reset is synchronous and active-high.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- alu_ctrl  in  4  operation select (codes below)
- alu_src  in  1  operand B select: 0 = src2, 1 = imm_signed
- src1  in  32  operand A (rs1 value)
- src2  in  32  register operand B (rs2 value)
- src  in  25  instruction bits [31:7]
- imm_src  in  3  immediate format select
- imm_signed  out  32  combinational sign-extended immediate
- results  out  32  registered ALU result
- zero  out  1  registered flag, 1 when the registered result equals 0

## Operation
- Immediate decode, combinational. Indices below refer to `src`, so src[24] is instr[31]:
  - 000 I: {20{src[24]}, src[24:13]}
  - 001 S: {20{src[24]}, src[24:18], src[4:0]}
  - 010 B: {19{src[24]}, src[24], src[0], src[23:18], src[4:1], 1'b0}
  - 011 U: {src[24:5], 12'b0}
  - 100 J: {11{src[24]}, src[24], src[12:5], src[13], src[23:14], 1'b0}
  - 101, 110, 111: 32'h0
- Operand B = alu_src ? imm_signed : src2.
- ALU codes:
  - 0000 ADD: A+B
  - 0001 SUB: A−B
  - 0010 AND
  - 0011 OR
  - 0100 XOR
  - 0101 SLL: A << B[4:0]
  - 0110 SRL: logical A >> B[4:0]
  - 0111 SRA: arithmetic A >> B[4:0]
  - 1000 SLT: signed A<B → 1, else 0
  - 1001 SLTU: unsigned compare, 1 or 0
  - 1111 NOP and every other code: 32'h0
- All arithmetic is modulo 2^32. Overflow and carry are discarded and not flagged.
- zero = (next result == 0). It is registered together with results.

## Timing
- imm_signed has zero latency (purely combinational).
- results and zero have one-cycle latency: at each rising clk edge they capture the function of the inputs present before that edge.
- When rst is high at an edge: results = 32'h0 and zero = 1. Reset overrides any concurrent operation.
- There is no handshake. A new operation is accepted every cycle.
- Outputs hold their value while the inputs are stable.

## Configuration
- `RV32I_ALU_SHIFT_CMP_EN` defined: SLL, SRL, SRA, SLT and SLTU are implemented as specified.
- Undefined: codes 0101–1001 fall into the default case and yield 32'h0. This saves area on load/store-only builds. ADD, SUB, AND, OR, XOR and the immediate decode are unaffected.

## Structure
- The shared package holds `INSTR_WIDTH`, the ALU opcode constants (ADD, SUB, …, NOP = 4'b1111) and the imm_src format codes.
- One natural sub-module: `sign_extend` (the combinational immediate decoder). The ALU mux, operation logic and output register stay in the top.

## Test plan
- Reset: rst=1, alu_ctrl=NOP, imm_src=111 → results=0, zero=1 after the edge; imm_signed=0.
- I-type negative: src=25'h1F80000, imm_src=000, ADD, alu_src=1, src1=0x2000 → imm_signed=0xFFFFFFC0; results=0x1FC0 one cycle later.
- S-type: src=25'h0070005, imm_src=001, ADD, alu_src=1, src1=0x3000 → imm_signed=0x25, results=0x3025. Then src=25'h1700005 with src1=0x4000 → imm_signed=0xFFFFFB85, results=0x3B85.
- Register path: alu_src=0, src1=0x5000, src2=0x0FFF, ADD → results=0x5FFF, zero=0.
- Zero and SUB: SUB with src1=src2=0x1234 → results=0, zero=1. Then NOP with any operands → results=0.
- Shifts and compares (macro defined): SRA with 0x80000000 and B=4 → 0xF8000000. SLT with 0xFFFFFFFF vs 1 → 1. SLTU with the same operands → 0. With the macro undefined, all three → 0.
